// File: rtl/ber_test_ctrl.sv
// BER test run controller: flushes the datapath chain, discards warm-up bits, then measures a bit/error window.
// Optional early stop on error count is compiled in with `define BER_CTRL_ERR_LIMIT_EN.
module ber_test_ctrl #(
    parameter int unsigned FLUSH_CYCLES   = 8,
    parameter int unsigned WARMUP_BITS    = 64,
    parameter int unsigned WINDOW_BITS    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned ERR_LIMIT      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] total_bits,
    input  logic [31:0] total_bit_errors,
    output logic        chain_rstn,
    output logic        chain_en,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] bits_measured,
    output logic [31:0] errors_measured
`ifdef BER_CTRL_ERR_LIMIT_EN
    ,
    output logic        err_limit_hit
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WARMUP,
        S_MEASURE,
        S_DONE
    } state_t;

    // ERR_LIMIT only takes effect when early stop is compiled in
`ifdef BER_CTRL_ERR_LIMIT_EN
    localparam bit ERR_STOP_EN = 1'b1;
`else
    localparam bit ERR_STOP_EN = 1'b0;
`endif

    state_t      state_reg, state_next;
    logic [7:0]  flush_cnt_reg, flush_cnt_next;
    logic [31:0] wd_cnt_reg, wd_cnt_next;
    logic [31:0] base_bits_reg, base_bits_next;
    logic [31:0] base_err_reg, base_err_next;
    logic [31:0] bits_meas_reg, bits_meas_next;
    logic [31:0] errs_meas_reg, errs_meas_next;
    logic        timeout_reg, timeout_next;
    logic        chain_rstn_reg, chain_en_reg, busy_reg, done_reg;
    logic        window_hit, err_hit, wd_hit;
`ifdef BER_CTRL_ERR_LIMIT_EN
    logic        elh_reg, elh_next;
`endif

    // Exit decisions use the registered window counts, so DONE follows one cycle after the count is computed
    assign window_hit = (bits_meas_reg >= 32'(WINDOW_BITS));
    assign err_hit    = ERR_STOP_EN && (errs_meas_reg >= 32'(ERR_LIMIT));
    assign wd_hit     = (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        wd_cnt_next    = wd_cnt_reg;
        base_bits_next = base_bits_reg;
        base_err_next  = base_err_reg;
        bits_meas_next = bits_meas_reg;
        errs_meas_next = errs_meas_reg;
        timeout_next   = timeout_reg;
`ifdef BER_CTRL_ERR_LIMIT_EN
        elh_next       = elh_reg;
`endif
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next     = S_FLUSH;
                        flush_cnt_next = '0;
                        bits_meas_next = '0;
                        errs_meas_next = '0;
                        timeout_next   = 1'b0;
`ifdef BER_CTRL_ERR_LIMIT_EN
                        elh_next       = 1'b0;
`endif
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_reg == 8'(FLUSH_CYCLES - 1)) begin
                        state_next  = S_WARMUP;
                        wd_cnt_next = '0;
                    end else begin
                        flush_cnt_next = flush_cnt_reg + 8'd1;
                    end
                end
                S_WARMUP: begin
                    wd_cnt_next = wd_cnt_reg + 32'd1;
                    if (wd_hit) begin
                        state_next   = S_DONE;
                        timeout_next = 1'b1;
                    end else if (total_bits >= 32'(WARMUP_BITS)) begin
                        state_next     = S_MEASURE;
                        base_bits_next = total_bits;
                        base_err_next  = total_bit_errors;
                    end
                end
                S_MEASURE: begin
                    wd_cnt_next = wd_cnt_reg + 32'd1;
                    // Window completion outranks the watchdog when both land in the same cycle
                    if (window_hit) begin
                        state_next = S_DONE;
                    end else if (err_hit) begin
                        state_next = S_DONE;
`ifdef BER_CTRL_ERR_LIMIT_EN
                        elh_next   = 1'b1;
`endif
                    end else if (wd_hit) begin
                        state_next   = S_DONE;
                        timeout_next = 1'b1;
                    end else begin
                        bits_meas_next = total_bits - base_bits_reg;
                        errs_meas_next = total_bit_errors - base_err_reg;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_IDLE;
            flush_cnt_reg  <= '0;
            wd_cnt_reg     <= '0;
            base_bits_reg  <= '0;
            base_err_reg   <= '0;
            bits_meas_reg  <= '0;
            errs_meas_reg  <= '0;
            timeout_reg    <= 1'b0;
            chain_rstn_reg <= 1'b0;
            chain_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flush_cnt_reg  <= flush_cnt_next;
            wd_cnt_reg     <= wd_cnt_next;
            base_bits_reg  <= base_bits_next;
            base_err_reg   <= base_err_next;
            bits_meas_reg  <= bits_meas_next;
            errs_meas_reg  <= errs_meas_next;
            timeout_reg    <= timeout_next;
            // Control outputs are decoded from the next state so they are registered yet track the state
            chain_rstn_reg <= (state_next == S_WARMUP) || (state_next == S_MEASURE) || (state_next == S_DONE);
            chain_en_reg   <= (state_next == S_WARMUP) || (state_next == S_MEASURE);
            busy_reg       <= (state_next == S_FLUSH) || (state_next == S_WARMUP) || (state_next == S_MEASURE);
            done_reg       <= (state_next == S_DONE);
        end
    end

`ifdef BER_CTRL_ERR_LIMIT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            elh_reg <= 1'b0;
        end else begin
            elh_reg <= elh_next;
        end
    end

    assign err_limit_hit = elh_reg;
`endif

    assign chain_rstn      = chain_rstn_reg;
    assign chain_en        = chain_en_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign timeout         = timeout_reg;
    assign bits_measured   = bits_meas_reg;
    assign errors_measured = errs_meas_reg;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Self-checking bench for ber_test_ctrl: directed run table, abort/reset sequences, randomized traces vs a trace-scan model.
module tb_ber_test_ctrl;

    localparam int F  = 8;
    localparam int WB = 64;
    localparam int W  = 1000;
    localparam int T  = 1500;
    localparam int L  = 16;
`ifdef BER_CTRL_ERR_LIMIT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] total_bits = '0;
    logic [31:0] total_bit_errors = '0;
    logic        chain_rstn, chain_en, busy, done, timeout;
    logic [31:0] bits_measured, errors_measured;
`ifdef BER_CTRL_ERR_LIMIT_EN
    logic        err_limit_hit;
`endif

    always #5 clk = ~clk;

    ber_test_ctrl #(
        .FLUSH_CYCLES  (F),
        .WARMUP_BITS   (WB),
        .WINDOW_BITS   (W),
        .TIMEOUT_CYCLES(T),
        .ERR_LIMIT     (L)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .total_bits      (total_bits),
        .total_bit_errors(total_bit_errors),
        .chain_rstn      (chain_rstn),
        .chain_en        (chain_en),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .bits_measured   (bits_measured),
        .errors_measured (errors_measured)
`ifdef BER_CTRL_ERR_LIMIT_EN
        ,
        .err_limit_hit   (err_limit_hit)
`endif
    );

    // Checker counter values seen k cycles into WARMUP (index 1..T)
    logic [31:0] bits_tr [0:T];
    logic [31:0] errs_tr [0:T];

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int          kind;
        int          ign_edge;
        int          exp_edge;
        logic [31:0] exp_bits;
        logic [31:0] exp_errs;
        logic        exp_to;
        logic        exp_elh;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic build_trace(input int kind);
        logic [31:0] b;
        logic [31:0] e;
        b = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
        e = $urandom;
        bits_tr[0] = '0;
        errs_tr[0] = '0;
        for (int k = 1; k <= T; k++) begin
            case (kind)
                0: begin bits_tr[k] = 32'(k); errs_tr[k] = '0; end
                1: begin bits_tr[k] = 32'(k); errs_tr[k] = (k > 64) ? 32'((k - 64) / 100) : 32'd0; end
                2: begin bits_tr[k] = 32'hFFFF_FF00 + 32'(k); errs_tr[k] = '0; end
                3: begin bits_tr[k] = '0; errs_tr[k] = '0; end
                4: begin bits_tr[k] = (k < T - 1) ? 32'(WB) : 32'(WB + W); errs_tr[k] = '0; end
                5: begin bits_tr[k] = 32'(k); errs_tr[k] = (k > 64) ? 32'((k - 64) / 10) : 32'd0; end
                6: begin
                    b = b + 32'($urandom_range(0, 3));
                    e = e + (($urandom_range(0, 40) == 0) ? 32'd1 : 32'd0);
                    bits_tr[k] = b; errs_tr[k] = e;
                end
                default: begin
                    b = b + (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0);
                    e = e + (($urandom_range(0, 60) == 0) ? 32'd1 : 32'd0);
                    bits_tr[k] = b; errs_tr[k] = e;
                end
            endcase
        end
    endtask

    // Scan the trace by the run rules: first warm-up crossing, then the first window/limit crossing,
    // DONE one cycle after that crossing, otherwise the watchdog ends the run after T cycles.
    task automatic predict(output int ex_edge, output logic [31:0] ex_bits, output logic [31:0] ex_errs,
                           output logic ex_to, output logic ex_elh);
        int          km;
        int          xk;
        bit          found;
        logic [31:0] mb;
        logic [31:0] me;
        km = 0;
        for (int k = 1; k < T; k++) begin
            if (km == 0 && bits_tr[k] >= 32'(WB)) km = k;
        end
        ex_bits = '0; ex_errs = '0; ex_to = 1'b1; ex_elh = 1'b0; xk = T; found = 1'b0;
        if (km != 0) begin
            for (int j = km + 1; j < T; j++) begin
                mb = bits_tr[j] - bits_tr[km];
                me = errs_tr[j] - errs_tr[km];
                if (!found) begin
                    if (mb >= 32'(W)) begin
                        found = 1'b1; xk = j + 1; ex_to = 1'b0; ex_bits = mb; ex_errs = me;
                    end else if (ERR_EN && me >= 32'(L)) begin
                        found = 1'b1; xk = j + 1; ex_to = 1'b0; ex_elh = 1'b1; ex_bits = mb; ex_errs = me;
                    end else if (j == T - 1) begin
                        ex_bits = mb; ex_errs = me;
                    end
                end
            end
        end
        ex_edge = F + xk;
    endtask

    // Inputs presented before the e-th rising edge after the start edge
    task automatic drive(input int e);
        int k;
        k = e - F;
        if (k < 1) begin
            total_bits = '0;
            total_bit_errors = '0;
        end else begin
            if (k > T) k = T;
            total_bits = bits_tr[k];
            total_bit_errors = errs_tr[k];
        end
    endtask

    task automatic do_run(input int id, input int ign_edge, input int exp_edge, input logic [31:0] exp_bits,
                          input logic [31:0] exp_errs, input logic exp_to, input logic exp_elh);
        int          low_cnt;
        int          done_edge;
        bit          seen;
        logic [31:0] held;
        @(negedge clk);
        start = 1'b1; total_bits = '0; total_bit_errors = '0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_clear_on_start", 32'(done), 32'd0);
        low_cnt = (chain_rstn == 1'b0) ? 1 : 0;
        seen = 1'b0;
        done_edge = 0;
        for (int e = 1; e <= F + T + 4 && !seen; e++) begin
            drive(e);
            start = (e == ign_edge);
            @(negedge clk);
            start = 1'b0;
            if (!chain_rstn) low_cnt++;
            if (done) begin
                seen = 1'b1;
                done_edge = e;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_edge", 32'(done_edge), 32'(exp_edge));
        check("bits_measured", bits_measured, exp_bits);
        check("errors_measured", errors_measured, exp_errs);
        check("timeout", 32'(timeout), 32'(exp_to));
`ifdef BER_CTRL_ERR_LIMIT_EN
        check("err_limit_hit", 32'(err_limit_hit), 32'(exp_elh));
`else
        if (exp_elh) check("err_limit_expected", 32'd0, 32'd1);
`endif
        check("busy_in_done", 32'(busy), 32'd0);
        check("chain_en_in_done", 32'(chain_en), 32'd0);
        check("chain_rstn_in_done", 32'(chain_rstn), 32'd1);
        check("flush_low_cycles", 32'(low_cnt), 32'(F));
        held = bits_measured;
        repeat (3) begin
            total_bits = total_bits + 32'd100;
            @(negedge clk);
        end
        check("done_holds", 32'(done), 32'd1);
        check("counts_frozen", bits_measured, held);
        $display("run %0d: done_edge=%0d bits=%0d errs=%0d timeout=%0b (expected edge=%0d bits=%0d errs=%0d timeout=%0b)",
                 id, done_edge, bits_measured, errors_measured, timeout, exp_edge, exp_bits, exp_errs, exp_to);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          ex_edge;
        logic [31:0] ex_bits;
        logic [31:0] ex_errs;
        logic        ex_to;
        logic        ex_elh;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_chain_rstn", 32'(chain_rstn), 32'd0);
        check("rst_chain_en", 32'(chain_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_bits", bits_measured, 32'd0);
        check("rst_errs", errors_measured, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // kind, stray start edge, done edge, bits, errs, timeout, err limit
        tbl.push_back('{0, F + 20,  F + 1065, 32'd1000, 32'd0,  1'b0, 1'b0}); // clean, start in WARMUP ignored
        tbl.push_back('{1, F + 500, F + 1065, 32'd1000, 32'd10, 1'b0, 1'b0}); // 1 err/100 bits, start in MEASURE ignored
        tbl.push_back('{2, 0,       F + 1002, 32'd1000, 32'd0,  1'b0, 1'b0}); // counter wraps through 2^32
        tbl.push_back('{3, 0,       F + T,    32'd0,    32'd0,  1'b1, 1'b0}); // frozen counter -> watchdog
        tbl.push_back('{4, 0,       F + T,    32'd1000, 32'd0,  1'b0, 1'b0}); // window and watchdog tie
`ifdef BER_CTRL_ERR_LIMIT_EN
        tbl.push_back('{5, 0,       F + 225,  32'd160,  32'd16, 1'b0, 1'b1}); // error limit early stop
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            build_trace(tbl[i].kind);
            do_run(i, tbl[i].ign_edge, tbl[i].exp_edge, tbl[i].exp_bits, tbl[i].exp_errs,
                   tbl[i].exp_to, tbl[i].exp_elh);
        end

        // Abort together with start during MEASURE
        build_trace(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e < F + 100; e++) begin
            drive(e);
            @(negedge clk);
        end
        drive(F + 100);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_chain_en", 32'(chain_en), 32'd0);
        check("abort_chain_rstn", 32'(chain_rstn), 32'd0);
        check("abort_bits_kept", bits_measured, 32'd35);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy | done), 32'd0);
        $display("abort: bits_measured=%0d busy=%0b done=%0b", bits_measured, busy, done);
        do_run(100, 0, F + 1065, 32'd1000, 32'd0, 1'b0, 1'b0);

        // Randomized traces against the model
        for (int r = 0; r < 6; r++) begin
            build_trace(6 + (r % 2));
            predict(ex_edge, ex_bits, ex_errs, ex_to, ex_elh);
            do_run(200 + r, 0, ex_edge, ex_bits, ex_errs, ex_to, ex_elh);
        end

        // Reset in the middle of a run
        build_trace(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= F + 200; e++) begin
            drive(e);
            @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_chain_en", 32'(chain_en), 32'd0);
        check("midrst_chain_rstn", 32'(chain_rstn), 32'd0);
        check("midrst_bits", bits_measured, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(done), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        $display("reset mid-run: busy=%0b done=%0b bits=%0d", busy, done, bits_measured);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
